// File: rtl/morse_decoder.sv
// morse_decoder: hand-keyed Morse button -> ASCII character strobe.
// Key is synchronized and debounced, mark/space lengths are measured in
// dot units, and each completed letter is emitted as one char_valid pulse.
// Optional macro WORD_SPACE_EN: emit 0x20 once after a word-length gap.

module morse_decoder #(
  parameter int unsigned TICK_DIV         = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned DOT_MAX_UNITS    = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic       char_err
);

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GAP_MAX = (WORD_GAP_UNITS > LETTER_GAP_UNITS) ? WORD_GAP_UNITS
                                                                        : LETTER_GAP_UNITS;
  localparam int unsigned GW      = $clog2(GAP_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DOT_MAX    = 4'(DOT_MAX_UNITS);
  localparam logic [GW-1:0] LG_LAST    = GW'(LETTER_GAP_UNITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MARK  = 3'd1;
  localparam logic [2:0] S_SPACE = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
`ifdef WORD_SPACE_EN
  localparam logic [2:0] S_WORD  = 3'd4;
  localparam logic [GW-1:0] WG_LAST = GW'(WORD_GAP_UNITS - 1);
`endif

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          key_level_q, key_level_d;
  logic          kl_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    state_q, state_d;
  logic [3:0]    mark_cnt_q, mark_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]    sym_len_q, sym_len_d;
  logic [5:0]    sym_bits_q, sym_bits_d;
  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    data_q, data_d;

  logic          ksync, rise, fall, tick, symbol;
  logic [3:0]    mark_units;
  logic [8:0]    lut;

  // {err, ascii} for a completed pattern; first symbol sits in the higher bit
  function automatic logic [8:0] lookup(input logic [2:0] len, input logic [5:0] bits);
    logic [8:0] r;
    r = {1'b1, 8'h3F};
    case ({len, bits})
      {3'd1, 6'b000000}: r = {1'b0, "E"};
      {3'd1, 6'b000001}: r = {1'b0, "T"};
      {3'd2, 6'b000000}: r = {1'b0, "I"};
      {3'd2, 6'b000001}: r = {1'b0, "A"};
      {3'd2, 6'b000010}: r = {1'b0, "N"};
      {3'd2, 6'b000011}: r = {1'b0, "M"};
      {3'd3, 6'b000000}: r = {1'b0, "S"};
      {3'd3, 6'b000001}: r = {1'b0, "U"};
      {3'd3, 6'b000010}: r = {1'b0, "R"};
      {3'd3, 6'b000011}: r = {1'b0, "W"};
      {3'd3, 6'b000100}: r = {1'b0, "D"};
      {3'd3, 6'b000101}: r = {1'b0, "K"};
      {3'd3, 6'b000110}: r = {1'b0, "G"};
      {3'd3, 6'b000111}: r = {1'b0, "O"};
      {3'd4, 6'b000000}: r = {1'b0, "H"};
      {3'd4, 6'b000001}: r = {1'b0, "V"};
      {3'd4, 6'b000010}: r = {1'b0, "F"};
      {3'd4, 6'b000100}: r = {1'b0, "L"};
      {3'd4, 6'b000110}: r = {1'b0, "P"};
      {3'd4, 6'b000111}: r = {1'b0, "J"};
      {3'd4, 6'b001000}: r = {1'b0, "B"};
      {3'd4, 6'b001001}: r = {1'b0, "X"};
      {3'd4, 6'b001010}: r = {1'b0, "C"};
      {3'd4, 6'b001011}: r = {1'b0, "Y"};
      {3'd4, 6'b001100}: r = {1'b0, "Z"};
      {3'd4, 6'b001101}: r = {1'b0, "Q"};
      {3'd5, 6'b000000}: r = {1'b0, "5"};
      {3'd5, 6'b000001}: r = {1'b0, "4"};
      {3'd5, 6'b000011}: r = {1'b0, "3"};
      {3'd5, 6'b000111}: r = {1'b0, "2"};
      {3'd5, 6'b001111}: r = {1'b0, "1"};
      {3'd5, 6'b010000}: r = {1'b0, "6"};
      {3'd5, 6'b011000}: r = {1'b0, "7"};
      {3'd5, 6'b011100}: r = {1'b0, "8"};
      {3'd5, 6'b011110}: r = {1'b0, "9"};
      {3'd5, 6'b011111}: r = {1'b0, "0"};
      default:           r = {1'b1, 8'h3F};
    endcase
    return r;
  endfunction

  assign ksync = sync_q[1];
  assign rise  = key_level_q & ~kl_prev_q;
  assign fall  = ~key_level_q & kl_prev_q;
  assign tick  = (presc_q == PRESC_LAST);

  // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles
  always_comb begin
    db_cnt_d    = '0;
    key_level_d = key_level_q;
    if (ksync != key_level_q) begin
      if (db_cnt_q == DB_LAST) key_level_d = ksync;
      else                     db_cnt_d    = db_cnt_q + 1'b1;
    end
  end

  // Unit prescaler, re-aligned to every debounced key edge
  always_comb begin
    presc_d = (rise | fall | tick) ? '0 : presc_q + 1'b1;
  end

  // Letter FSM; the final tick of a mark is counted even when it meets the falling edge
  always_comb begin
    state_d    = state_q;
    mark_cnt_d = mark_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sym_len_d  = sym_len_q;
    sym_bits_d = sym_bits_q;
    pend_d     = pend_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;
    mark_units = (tick && mark_cnt_q != 4'hF) ? mark_cnt_q + 4'd1 : mark_cnt_q;
    symbol     = (mark_units >= DOT_MAX);
    lut        = lookup(sym_len_q, sym_bits_q);
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d    = S_MARK;
          mark_cnt_d = '0;
        end
      end
      S_MARK: begin
        mark_cnt_d = mark_units;
        if (fall) begin
          sym_bits_d = {sym_bits_q[4:0], symbol};
          if (sym_len_q != 3'd6) sym_len_d = sym_len_q + 3'd1;
          gap_cnt_d  = '0;
          state_d    = S_SPACE;
        end
      end
      S_SPACE: begin
        // Strobe is registered here so it appears in the EMIT cycle; a
        // coincident key edge is parked in pend_q rather than dropped.
        if (tick && gap_cnt_q == LG_LAST) begin
          gap_cnt_d       = gap_cnt_q + 1'b1;
          valid_d         = 1'b1;
          {err_d, data_d} = lut;
          pend_d          = rise;
          state_d         = S_EMIT;
        end else if (rise) begin
          state_d    = S_MARK;
          mark_cnt_d = '0;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        sym_len_d  = '0;
        sym_bits_d = '0;
        pend_d     = 1'b0;
        if (pend_q || rise) begin
          state_d    = S_MARK;
          mark_cnt_d = '0;
        end else begin
`ifdef WORD_SPACE_EN
          state_d = S_WORD;
          if (tick) gap_cnt_d = gap_cnt_q + 1'b1;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef WORD_SPACE_EN
      S_WORD: begin
        if (rise) begin
          state_d    = S_MARK;
          mark_cnt_d = '0;
        end else if (tick) begin
          if (gap_cnt_q == WG_LAST) begin
            valid_d = 1'b1;
            data_d  = 8'h20;
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      key_level_q <= 1'b0;
      kl_prev_q   <= 1'b0;
      presc_q     <= '0;
      state_q     <= S_IDLE;
      mark_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      sym_len_q   <= '0;
      sym_bits_q  <= '0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], key_in};
      db_cnt_q    <= db_cnt_d;
      key_level_q <= key_level_d;
      kl_prev_q   <= key_level_q;
      presc_q     <= presc_d;
      state_q     <= state_d;
      mark_cnt_q  <= mark_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sym_len_q   <= sym_len_d;
      sym_bits_q  <= sym_bits_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      data_q      <= data_d;
    end
  end

  assign key_level  = key_level_q;
  assign char_valid = valid_q;
  assign char_data  = data_q;
  assign char_err   = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed plus randomized keying of Morse letters,
// checked against a table-driven reference of International Morse.

module tb_morse_decoder;

  localparam int TD  = 4;
  localparam int DB  = 2;
  localparam int LG  = 3;
  localparam int WG  = 7;
  // key_in change -> strobe: 2 sync flops + debounce + letter gap + emit cycle
  localparam int LAT = 2 + DB + LG * TD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic       key_level, char_valid, char_err;
  logic [7:0] char_data;

  morse_decoder #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB),
    .DOT_MAX_UNITS(2),
    .LETTER_GAP_UNITS(LG),
    .WORD_GAP_UNITS(WG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_err(char_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       e;
  } strobe_t;

  strobe_t sq[$];
  int      err_no_valid = 0;

  always @(negedge clk) begin
    if (char_valid === 1'b1) sq.push_back('{cyc, char_data, char_err});
    else if (char_err !== 1'b0) err_no_valid++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  string codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  function automatic logic [7:0] ch(input int i);
    return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
  endfunction

  // Reference: {err, ascii} by searching the Morse table for the keyed string
  function automatic logic [8:0] model(input string code);
    for (int i = 0; i < 36; i++)
      if (codes[i] == code) return {1'b0, ch(i)};
    return {1'b1, 8'h3F};
  endfunction

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Key a pattern: dot = 1 unit, dash = 3 units, 1-unit gaps; optional jitter
  task automatic send(input string code, input bit jitter, output int rel);
    int j;
    for (int i = 0; i < code.len(); i++) begin
      j = jitter ? int'($urandom_range(0, 2)) : 0;
      hold(1'b1, ((code[i] == "-") ? 3 * TD : TD) + j);
      if (i != code.len() - 1) begin
        j = jitter ? int'($urandom_range(0, 2)) : 0;
        hold(1'b0, TD + j);
      end
    end
    key_in = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_strobe(input int budget, output bit got, output strobe_t s);
    got = 1'b0;
    s   = '{0, 8'h00, 1'b0};
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      #1;
      if (sq.size() > 0) begin
        s   = sq.pop_front();
        got = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    strobe_t    s, s2;
    bit         got;
    int         rel, rel2, ec;
    logic       kl_seen;
    logic [8:0] exp;
    string      code;
    string      dcode[4] = '{".-", "-", "-----", "......"};
    logic [8:0] dexp[4]  = '{{1'b0, 8'h41}, {1'b0, 8'h54}, {1'b0, 8'h30}, {1'b1, 8'h3F}};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_key_level", key_level, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_data", char_data, 0);
    check("rst_char_err", char_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single dot -> 'E', exact strobe latency, one-cycle pulse, data held
    send(".", 1'b0, rel);
    wait_strobe(LAT + 8, got, s);
    check("E_got", got, 1);
    check("E_data", s.d, 8'h45);
    check("E_err", s.e, 0);
    check("E_latency", s.c - rel, LAT);
    @(negedge clk);
    #1;
    check("E_pulse_width", char_valid, 0);
    check("E_data_hold", char_data, 8'h45);

    // Directed letters including overflow
    for (int i = 0; i < 4; i++) begin
      send(dcode[i], 1'b0, rel);
      wait_strobe(LAT + 8, got, s);
      check($sformatf("dir%0d_got", i), got, 1);
      check($sformatf("dir%0d_data", i), s.d, dexp[i][7:0]);
      check($sformatf("dir%0d_err", i), s.e, dexp[i][8]);
    end

    // Sub-debounce glitch during the space
    send(".", 1'b0, rel);
    hold(1'b0, TD);
    key_in = 1'b1;
    @(negedge clk);
    key_in  = 1'b0;
    kl_seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      kl_seen = kl_seen | key_level;
    end
    check("glitch_key_level", kl_seen, 0);
    wait_strobe(LAT + 8, got, s);
    check("glitch_data", s.d, 8'h45);
    check("glitch_latency", s.c - rel, LAT);

    // Key edge coinciding with the letter-gap tick, then during EMIT
    for (int off = LG * TD; off <= LG * TD + 1; off++) begin
      send(".", 1'b0, rel);
      repeat (off) @(negedge clk);
      send(".", 1'b0, rel2);
      wait_strobe(LAT + 8, got, s);
      check($sformatf("coinc%0d_first_data", off), s.d, 8'h45);
      check($sformatf("coinc%0d_first_latency", off), s.c - rel, LAT);
      wait_strobe(LAT + 8, got, s);
      check($sformatf("coinc%0d_second_got", off), got, 1);
      check($sformatf("coinc%0d_second_data", off), s.d, 8'h45);
    end

    // Reset mid-letter discards the partial pattern
    send("..", 1'b0, rel);
    hold(1'b0, TD);
    key_in = 1'b1;
    for (int n = 0; n < 10 && key_level !== 1'b1; n++) @(negedge clk);
    check("midrst_pre_key_level", key_level, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_key_level", key_level, 0);
    check("midrst_char_valid", char_valid, 0);
    check("midrst_char_data", char_data, 0);
    check("midrst_char_err", char_err, 0);
    key_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6 * TD) @(negedge clk);
    check("midrst_no_strobe", sq.size(), 0);
    send(".", 1'b0, rel);
    wait_strobe(LAT + 8, got, s);
    check("midrst_next_data", s.d, 8'h45);
    check("midrst_next_err", s.e, 0);

    // Randomized letters and random patterns with timing jitter
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        code = codes[$urandom_range(0, 35)];
      end else begin
        code = "";
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
          if ($urandom_range(0, 1) == 1) code = {code, "-"};
          else                           code = {code, "."};
        end
      end
      exp = model(code);
      send(code, 1'b1, rel);
      wait_strobe(LAT + 12, got, s);
      check($sformatf("rand%0d_got(%s)", i, code), got, 1);
      check($sformatf("rand%0d_data(%s)", i, code), s.d, exp[7:0]);
      check($sformatf("rand%0d_err(%s)", i, code), s.e, exp[8]);
    end

    // Dot followed by a long idle: word space only when the feature is built
    send(".", 1'b0, rel);
    wait_strobe(LAT + 8, got, s);
    check("word_letter_data", s.d, 8'h45);
    ec = s.c;
    wait_strobe(WG * TD + 8, got, s2);
`ifdef WORD_SPACE_EN
    check("word_space_got", got, 1);
    check("word_space_data", s2.d, 8'h20);
    check("word_space_err", s2.e, 0);
    check("word_space_delay", s2.c - ec, (WG - LG) * TD);
`else
    check("word_no_space", got, 0);
`endif

    repeat (4 * TD) @(negedge clk);
    check("no_extra_strobes", sq.size(), 0);
    check("err_without_valid", err_no_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
